alu_op_sequencer: RTL and testbench

//  Initiator side of the ALU operand/select interface. Accepts one operation request
//  at a time, drives alu_a/alu_b/alu_select, captures alu_c into the 64-bit Z pair
//  (z_hi/z_lo). MUL and DIV are executed internally as signed, iterative 32-cycle

---
 rtl/alu_op_sequencer_pkg.sv | 17 +
 rtl/alu_op_sequencer_muldiv_iter.sv | 49 ++++
 rtl/alu_op_sequencer.sv | 90 +++++++++
 tb/tb_alu_op_sequencer.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/alu_op_sequencer_pkg.sv
// alu_op_sequencer_pkg: ALU opcodes, sequencer state encoding and magnitude helper
package mini_src_pkg;
  localparam int W = 32;
  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SUB = 5'b00001;
  localparam logic [4:0] ALU_AND = 5'b00010;
  localparam logic [4:0] ALU_OR  = 5'b00011;
  localparam logic [4:0] ALU_SHL = 5'b00100;
  localparam logic [4:0] ALU_NOT = 5'b00101;
  localparam logic [4:0] ALU_SHR = 5'b00111;
  localparam logic [4:0] ALU_MUL = 5'b01000;
  localparam logic [4:0] ALU_DIV = 5'b01001;
  typedef enum logic [2:0] {IDLE, EXEC, ITER, FIX, DONE} state_t;
  function automatic logic [W-1:0] mag(input logic [W-1:0] v);
    return v[W-1] ? -v : v;
  endfunction
endpackage

// File: rtl/alu_op_sequencer_muldiv_iter.sv
// muldiv_iter: 32-step signed shift-add multiply / restoring divide with sign fix
module muldiv_iter
  import mini_src_pkg::*;
(
  input  logic         clk,
  input  logic         clr_n,
  input  logic         start,
  input  logic         is_div,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo,
  output logic         done
);
  logic [W-1:0] ph, pl, mb, rs;
  logic [W:0] sum;
  logic [2*W-1:0] prod;
  logic [5:0] cnt;
  logic run, div, sa, sb, ge;
  // remainder stays below the divisor (<= 2^31), so the shifted partial remainder fits in W bits
  always_comb begin
    sum = {1'b0, ph} + {1'b0, mb};
    rs = {ph[W-2:0], pl[W-1]};
    ge = rs >= mb;
    prod = (sa ^ sb) ? -{ph, pl} : {ph, pl};
    hi = div ? (sa ? -ph : ph) : prod[2*W-1:W];
    lo = div ? ((sa ^ sb) ? -pl : pl) : prod[W-1:0];
  end
  assign done = run && cnt == 6'd31;
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      {ph, pl, mb, cnt, run, div, sa, sb} <= '0;
    end else if (start) begin
      ph <= '0;
      pl <= is_div ? mag(a) : mag(b);
      mb <= is_div ? mag(b) : mag(a);
      cnt <= '0;
      run <= 1'b1;
      div <= is_div;
      sa <= a[W-1];
      sb <= b[W-1];
    end else if (run) begin
      cnt <= cnt + 6'd1;
      run <= cnt != 6'd31;
      ph <= div ? (ge ? rs - mb : rs) : (pl[0] ? sum[W:1] : {1'b0, ph[W-1:1]});
      pl <= div ? {pl[W-2:0], ge} : {pl[0] ? sum[0] : ph[0], pl[W-1:1]};
    end
  end
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: request FSM driving the ALU and collecting a 64-bit Z result
module alu_op_sequencer
  import mini_src_pkg::*;
#(
  parameter int         WIDTH  = W,
  parameter logic [4:0] OP_MUL = ALU_MUL,
  parameter logic [4:0] OP_DIV = ALU_DIV
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [4:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [4:0]       alu_select,
  input  logic [WIDTH-1:0] alu_c,
  output logic [WIDTH-1:0] z_hi,
  output logic [WIDTH-1:0] z_lo,
  output logic             z_valid,
  output logic             busy,
  output logic             div_by_zero
);
  state_t state, nxt;
  logic [WIDTH-1:0] ra, rb, md_hi, md_lo;
  logic [4:0] rop;
  logic acc, is_mul, is_div, b_zero, dz, md_done;
  assign is_mul = req_op == OP_MUL;
  assign is_div = req_op == OP_DIV;
  assign b_zero = req_b == '0;
  assign acc = req_valid && req_ready;
  muldiv_iter u_md (
    .clk    (clk),
    .clr_n  (clr_n),
    .start  (acc && (is_mul || (is_div && !b_zero))),
    .is_div (is_div),
    .a      (req_a),
    .b      (req_b),
    .hi     (md_hi),
    .lo     (md_lo),
    .done   (md_done)
  );
  always_ff @(posedge clk) begin
    if (!clr_n) state <= IDLE;
    else state <= nxt;
  end
  always_comb begin
    nxt = state == IDLE ? (!acc ? IDLE : is_mul ? ITER : is_div ? (b_zero ? DONE : ITER) : EXEC)
        : state == EXEC ? DONE
        : state == ITER ? (md_done ? FIX : ITER)
        : state == FIX  ? DONE : IDLE;
  end
  always_comb begin
    req_ready = clr_n && state == IDLE;
    busy = state != IDLE;
    z_valid = state == DONE;
    div_by_zero = z_valid && dz;
    alu_a = state == EXEC ? ra : '0;
    alu_b = state == EXEC ? rb : '0;
    alu_select = state == EXEC ? rop : 5'b00000;
  end
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      {ra, rb, rop, z_hi, z_lo, dz} <= '0;
    end else begin
      if (acc) begin
        ra <= req_a;
        rb <= req_b;
        rop <= req_op;
      end
      if (acc && is_div && b_zero) begin
        z_hi <= req_a;
        z_lo <= '1;
        dz <= 1'b1;
      end
      if (state == EXEC) begin
        z_hi <= '0;
        z_lo <= alu_c;
        dz <= 1'b0;
      end
      if (state == FIX) begin
        z_hi <= md_hi;
        z_lo <= md_lo;
        dz <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed checks of ALU pass-through, MUL/DIV, reset abort and back-to-back flow
module tb_alu_op_sequencer;
  import mini_src_pkg::*;
  logic clk = 1'b0, clr_n = 1'b0, req_valid = 1'b0;
  logic [4:0] req_op = '0;
  logic [31:0] req_a = '0, req_b = '0, alu_c;
  logic req_ready, z_valid, busy, div_by_zero;
  logic [31:0] alu_a, alu_b, z_hi, z_lo;
  logic [4:0] alu_select;
  int total = 0, bad = 0;

  alu_op_sequencer dut (
    .clk(clk), .clr_n(clr_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .alu_a(alu_a), .alu_b(alu_b),
    .alu_select(alu_select), .alu_c(alu_c), .z_hi(z_hi), .z_lo(z_lo),
    .z_valid(z_valid), .busy(busy), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  always_comb begin
    alu_c = alu_select == ALU_ADD ? alu_a + alu_b
          : alu_select == ALU_SUB ? alu_a - alu_b
          : alu_select == ALU_AND ? alu_a & alu_b
          : alu_select == ALU_OR  ? alu_a | alu_b
          : alu_select == ALU_SHL ? alu_a << alu_b[4:0]
          : alu_select == ALU_NOT ? ~alu_a
          : alu_select == ALU_SHR ? alu_a >> alu_b[4:0] : 32'h0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic [4:0] sel1, output logic busy1);
    int n = 0;
    while (!req_ready && n < 50) begin tick(); n++; end
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    sel1 = alu_select;
    busy1 = busy;
    lat = 1;
    while (!z_valid && lat < 100) begin tick(); lat++; end
  endtask

  task automatic test_reset();
    clr_n = 1'b0;
    tick(); tick();
    total++; if ({z_valid, busy, req_ready, div_by_zero} !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b want=0000", {z_valid, busy, req_ready, div_by_zero}); end
    total++; if ({z_hi, z_lo} !== 64'h0) begin bad++; $display("FAIL reset_z got=%h want=0", {z_hi, z_lo}); end
    total++; if ({alu_a, alu_b, alu_select} !== 69'h0) begin bad++; $display("FAIL reset_alu got=%h want=0", {alu_a, alu_b, alu_select}); end
    clr_n = 1'b1;
    tick();
    total++; if ({req_ready, busy} !== 2'b10) begin bad++; $display("FAIL reset_release got=%b want=10", {req_ready, busy}); end
  endtask

  task automatic test_add();
    int lat; logic [4:0] s; logic b1;
    issue(ALU_ADD, 32'd5, 32'd7, lat, s, b1);
    total++; if (lat !== 2) begin bad++; $display("FAIL add_latency got=%0d want=2", lat); end
    total++; if (s !== 5'b00000) begin bad++; $display("FAIL add_select got=%b want=00000", s); end
    total++; if ({z_hi, z_lo} !== {32'd0, 32'd12}) begin bad++; $display("FAIL add_z got=%h want=%h", {z_hi, z_lo}, {32'd0, 32'd12}); end
    total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL add_dz got=%b want=0", div_by_zero); end
  endtask

  task automatic test_shl();
    int lat; logic [4:0] s; logic b1;
    issue(ALU_SHL, 32'd1, 32'd4, lat, s, b1);
    total++; if (z_lo !== 32'd16 || lat !== 2) begin bad++; $display("FAIL shl_z got=%0d lat=%0d want=16 lat=2", z_lo, lat); end
    total++; if ({b1, busy} !== 2'b11) begin bad++; $display("FAIL shl_busy_c12 got=%b want=11", {b1, busy}); end
    tick();
    total++; if ({busy, req_ready, z_valid} !== 3'b010) begin bad++; $display("FAIL shl_idle got=%b want=010", {busy, req_ready, z_valid}); end
    total++; if (z_lo !== 32'd16 || alu_select !== 5'b0) begin bad++; $display("FAIL shl_hold got=%0d sel=%b want=16 sel=0", z_lo, alu_select); end
  endtask

  task automatic test_mul();
    int lat; logic [4:0] s; logic b1;
    issue(ALU_MUL, 32'hFFFF_FFFA, 32'd7, lat, s, b1);
    total++; if (lat !== 34) begin bad++; $display("FAIL mul_latency got=%0d want=34", lat); end
    total++; if ({z_hi, z_lo} !== 64'hFFFF_FFFF_FFFF_FFD6) begin bad++; $display("FAIL mul_neg got=%h want=ffffffffffffffd6", {z_hi, z_lo}); end
    tick();
    total++; if (z_valid !== 1'b0 || z_lo !== 32'hFFFF_FFD6) begin bad++; $display("FAIL mul_hold got zv=%b lo=%h want zv=0 lo=ffffffd6", z_valid, z_lo); end
    issue(ALU_MUL, 32'h1234_5678, 32'h10, lat, s, b1);
    total++; if ({z_hi, z_lo} !== 64'h0000_0001_2345_6780) begin bad++; $display("FAIL mul_pos got=%h want=0000000123456780", {z_hi, z_lo}); end
    issue(ALU_MUL, 32'h8000_0000, 32'h8000_0000, lat, s, b1);
    total++; if ({z_hi, z_lo} !== 64'h4000_0000_0000_0000) begin bad++; $display("FAIL mul_min got=%h want=4000000000000000", {z_hi, z_lo}); end
  endtask

  task automatic test_div();
    int lat; logic [4:0] s; logic b1;
    issue(ALU_DIV, 32'hFFFF_FFEF, 32'd5, lat, s, b1);
    total++; if (lat !== 34) begin bad++; $display("FAIL div_latency got=%0d want=34", lat); end
    total++; if ({z_hi, z_lo, div_by_zero} !== {32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0}) begin bad++; $display("FAIL div_neg got=%h_%h dz=%b want=fffffffe_fffffffd dz=0", z_hi, z_lo, div_by_zero); end
    issue(ALU_DIV, 32'd100, 32'hFFFF_FFF9, lat, s, b1);
    total++; if ({z_hi, z_lo} !== {32'd2, 32'hFFFF_FFF2}) begin bad++; $display("FAIL div_negb got=%h_%h want=00000002_fffffff2", z_hi, z_lo); end
    issue(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, s, b1);
    total++; if ({z_hi, z_lo} !== {32'd0, 32'h8000_0000}) begin bad++; $display("FAIL div_wrap got=%h_%h want=00000000_80000000", z_hi, z_lo); end
    issue(ALU_DIV, 32'd9, 32'd0, lat, s, b1);
    total++; if (lat !== 1) begin bad++; $display("FAIL div0_latency got=%0d want=1", lat); end
    total++; if ({div_by_zero, z_hi, z_lo} !== {1'b1, 32'd9, 32'hFFFF_FFFF}) begin bad++; $display("FAIL div0_z got dz=%b %h_%h want dz=1 00000009_ffffffff", div_by_zero, z_hi, z_lo); end
  endtask

  task automatic test_abort();
    int seen = 0, n = 0;
    while (!req_ready && n < 50) begin tick(); n++; end
    req_op = ALU_MUL; req_a = 32'd3; req_b = 32'd5; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int i = 1; i < 10; i++) begin seen += int'(z_valid); tick(); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL abort_busy_c10 got=%b want=1", busy); end
    clr_n = 1'b0;
    tick();
    total++; if ({z_valid, busy, req_ready, div_by_zero, z_hi, z_lo, alu_select} !== '0) begin bad++; $display("FAIL abort_zero got=%b%b%b%b %h_%h %b want all 0", z_valid, busy, req_ready, div_by_zero, z_hi, z_lo, alu_select); end
    clr_n = 1'b1;
    tick();
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL abort_ready got=%b want=1", req_ready); end
    for (int i = 0; i < 40; i++) begin seen += int'(z_valid); tick(); end
    total++; if (seen !== 0) begin bad++; $display("FAIL abort_no_zvalid got=%0d want=0", seen); end
  endtask

  task automatic test_back_to_back();
    logic [12:0] mask = '0;
    logic [12:0] want = 13'b0_1001_0010_0100;
    int badz = 0;
    req_op = ALU_ADD; req_a = 32'd3; req_b = 32'd4; req_valid = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      mask[k] = z_valid;
      if (z_valid && z_lo !== 32'd7) badz++;
    end
    req_valid = 1'b0;
    total++; if (mask !== want) begin bad++; $display("FAIL b2b_pulses got=%b want=%b", mask, want); end
    total++; if (badz !== 0) begin bad++; $display("FAIL b2b_z got=%0d wrong results want=0", badz); end
    tick(); tick(); tick();
  endtask

  initial begin
    test_reset();
    test_add();
    test_shl();
    test_mul();
    test_div();
    test_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
